// File: rtl/frame_dumper_pkg.sv
// frame_dumper_pkg
//   Shared types and constants for the frame read-out path: FSM state
//   encoding, bytes per memory word and a helper that turns an image size
//   into a memory word count.
package frame_dumper_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    DONE
  } dump_state_t;

  // Number of 32-bit memory words occupied by a width x height 8-bit image.
  function automatic int words(input int width, input int height);
    return (width * height) / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/frame_dumper_if.sv
// frame_dumper_if
//   Bundles the control, memory-read and UART-byte signals of frame_dumper.
//   master : the dumper itself (drives busy/done/memory request/tx byte)
//   slave  : the environment (drives start, read data and tx_ack)
//   Signals: start, busy, done, mem_en, mem_we, mem_addr[ADDR_WIDTH],
//            mem_dr[32], tx_data[8], tx_stb, tx_ack
interface frame_dumper_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_dr;
  logic [7:0]            tx_data;
  logic                  tx_stb;
  logic                  tx_ack;

  modport master (
    input  start, mem_dr, tx_ack,
    output busy, done, mem_en, mem_we, mem_addr, tx_data, tx_stb
  );

  modport slave (
    output start, mem_dr, tx_ack,
    input  busy, done, mem_en, mem_we, mem_addr, tx_data, tx_stb
  );
endinterface

// File: rtl/frame_dumper_word_serializer.sv
// frame_dumper_word_serializer
//   Holds one 32-bit memory word and hands it out as 4 bytes, least
//   significant byte first.
//   Ports: clk, rst (async, active-high)
//          load     - capture word, restart at byte 0
//          word     - 32-bit word to capture
//          advance  - current byte was accepted downstream
//          byte_out - byte currently presented (registered)
//          last     - the 4th byte is being accepted this cycle
module frame_dumper_word_serializer
  import frame_dumper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        advance,
  output logic [7:0]  byte_out,
  output logic        last
);

  localparam int BCNT_W = $clog2(BYTES_PER_WORD);

  logic [31:0]       shift_reg;
  logic [BCNT_W-1:0] byte_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (load) begin
      shift_reg    <= word;
      byte_cnt_reg <= '0;
    end else if (advance) begin
      shift_reg    <= {8'h00, shift_reg[31:8]};
      byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);
    end
  end

  assign byte_out = shift_reg[7:0];
  assign last     = advance && (byte_cnt_reg == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/frame_dumper.sv
// frame_dumper
//   Reads the result image out of the shared image memory, one 32-bit word
//   (4 pixels) at a time starting at BASE_ADDR, and streams it to the UART
//   as bytes, little-endian within each word.
//   Ports: clk, rst (async, active-high)
//          bus (frame_dumper_if.master): start, busy, done, mem_en, mem_we,
//          mem_addr, mem_dr, tx_data, tx_stb, tx_ack
//   Every output is decoded from registered state only; tx_ack and mem_dr
//   only steer the next state and the serializer registers.
module frame_dumper
  import frame_dumper_pkg::*;
#(
  parameter int WIDTH      = 352,
  parameter int HEIGHT     = 288,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = words(WIDTH, HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  frame_dumper_if.master bus
);

  localparam int WORDS = words(WIDTH, HEIGHT);
  // A one-word frame still needs a 1-bit counter.
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  dump_state_t      state_reg, state_next;
  logic [CNT_W-1:0] word_cnt_reg;
  logic             advance;
  logic             ser_last;
  logic [7:0]       ser_byte;

  assign advance = (state_reg == SEND) && bus.tx_ack;

  frame_dumper_word_serializer u_word_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg == LATCH),
    .word     (bus.mem_dr),
    .advance  (advance),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  // State register and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        word_cnt_reg <= '0;
      end else if (ser_last && (word_cnt_reg != LAST_CNT)) begin
        word_cnt_reg <= word_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = READ;
      READ:    state_next = LATCH;
      LATCH:   state_next = SEND;
      SEND: begin
        if (ser_last) begin
          state_next = (word_cnt_reg == LAST_CNT) ? DONE : READ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. The address is forced to 0 in IDLE so the idle bus is
  // quiet; elsewhere it tracks the current word.
  always_comb begin
    bus.busy     = (state_reg != IDLE);
    bus.done     = (state_reg == DONE);
    bus.mem_en   = (state_reg == READ);
    bus.tx_stb   = (state_reg == SEND);
    bus.mem_addr = '0;
    if (state_reg != IDLE) begin
      bus.mem_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_cnt_reg);
    end
  end

  assign bus.mem_we  = 1'b0;
  assign bus.tx_data = ser_byte;

endmodule

// File: tb/tb_frame_dumper.sv
// tb_frame_dumper
//   Small 8x2 frame (4 words) at word address 100. Stimulus pushes the
//   expected address and byte sequences into queues; a monitor on the
//   falling edge pops and compares them whenever the dumper reads memory
//   or transfers a byte.
module tb_frame_dumper;

  localparam int AW    = 16;
  localparam int BASE  = 100;
  localparam int NW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_dumper_if #(.ADDR_WIDTH(AW)) bus ();

  frame_dumper #(
    .WIDTH      (8),
    .HEIGHT     (2),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem_words [NW] = '{32'h44332211, 32'h88776655,
                                  32'hCCBBAA99, 32'h00FFEEDD};
  logic [7:0]  frame_exp [NW*4] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                    8'h55, 8'h66, 8'h77, 8'h88,
                                    8'h99, 8'hAA, 8'hBB, 8'hCC,
                                    8'hDD, 8'hEE, 8'hFF, 8'h00};

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_count = 0;
  int frame_bytes = 0;
  int stall_byte = -1;
  int stall_left = 0;
  bit we_seen    = 1'b0;

  logic [7:0]    exp_bytes [$];
  logic [AW-1:0] exp_addr  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin : mem_model
    int idx;
    if (bus.mem_en) begin
      idx = int'(bus.mem_addr) - BASE;
      if (idx >= 0 && idx < NW) bus.mem_dr <= mem_words[idx];
      else                      bus.mem_dr <= 32'hDEADBEEF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART side: ack every byte, except for an optional stall on one byte index.
  initial begin
    bus.tx_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_stb && frame_bytes == stall_byte && stall_left > 0) begin
        bus.tx_ack = 1'b0;
        stall_left--;
      end else begin
        bus.tx_ack = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) we_seen = 1'b1;
      if (bus.mem_en) begin
        if (exp_addr.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_read: got addr %0d, want no read", bus.mem_addr);
        end else begin
          check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
        end
      end
      if (bus.tx_stb && bus.tx_ack) begin
        if (exp_bytes.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_byte: got 0x%02h, want none", bus.tx_data);
        end else begin
          $display("byte %0d: 0x%02h (cycle %0d)", frame_bytes, bus.tx_data, cyc);
          check("tx_byte", 32'(bus.tx_data), 32'(exp_bytes.pop_front()));
        end
        frame_bytes++;
      end else if (bus.tx_stb && !bus.tx_ack && exp_bytes.size() != 0) begin
        check("stall_hold", 32'(bus.tx_data), 32'(exp_bytes[0]));
      end
      if (bus.done) done_count++;
    end
  end

  task automatic push_frame();
    for (int i = 0; i < NW; i++) exp_addr.push_back(AW'(BASE + i));
    for (int i = 0; i < NW*4; i++) exp_bytes.push_back(frame_exp[i]);
  endtask

  task automatic pulse_start(output int n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Start sampled at cycle n: read at n+1, latch at n+2, first byte at n+3.
  task automatic check_latency();
    @(negedge clk);
    check("mem_en_n1", 32'(bus.mem_en), 32'd1);
    check("addr_n1", 32'(bus.mem_addr), BASE);
    @(negedge clk);
    check("stb_n2", 32'(bus.tx_stb), 32'd0);
    check("busy_n2", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("stb_n3", 32'(bus.tx_stb), 32'd1);
    check("data_n3", 32'(bus.tx_data), 32'h11);
  endtask

  task automatic wait_done(input int n, input int exp_off, input string name);
    int at;
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      compared++; mismatched++;
      $display("FAIL %s: got no done pulse, want one within 300 cycles", name);
    end else begin
      check(name, 32'(at - n), 32'(exp_off));
    end
  endtask

  task automatic check_quiet(input string name);
    check(name, 32'({bus.busy, bus.done, bus.mem_en, bus.mem_we, bus.tx_stb,
                     bus.tx_data, bus.mem_addr}), 32'd0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;

    // Reset values while reset is held.
    @(negedge clk);
    check_quiet("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with no start.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_quiet("idle_outputs");
    end

    // Frame A: ack always high.
    push_frame(); frame_bytes = 0;
    pulse_start(n);
    check_latency();
    wait_done(n, 25, "done_cycle_a");
    @(posedge clk); #1;
    check("done_count_a", 32'(done_count), 32'd1);
    check("idle_after_a", 32'(bus.busy), 32'd0);

    // Frame B: 5-cycle stall on byte 2, start pulsed while in SEND.
    push_frame(); frame_bytes = 0;
    stall_byte = 2; stall_left = 5;
    pulse_start(n);
    check_latency();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(n, 30, "done_cycle_b");
    @(posedge clk); #1;
    check("done_count_b", 32'(done_count), 32'd2);
    stall_byte = -1;

    // Frames C1/C2: start held high retriggers after DONE.
    push_frame(); push_frame(); frame_bytes = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    n = cyc;
    wait_done(n, 25, "done_cycle_c1");
    @(posedge clk); #1;
    check("idle_between", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("retrigger_busy", 32'(bus.busy), 32'd1);
    check("retrigger_read", 32'(bus.mem_en), 32'd1);
    wait_done(n, 51, "done_cycle_c2");
    @(posedge clk); #1;
    check("done_count_c", 32'(done_count), 32'd4);

    // Frame D: reset during word 1, no done pulse expected.
    push_frame(); frame_bytes = 0;
    pulse_start(n);
    begin : find_word1
      bit found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge clk);
        if (bus.mem_en && int'(bus.mem_addr) == BASE + 1) found = 1'b1;
      end
      check("abort_reached_word1", 32'(found), 32'd1);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_quiet("abort_outputs");
    exp_addr.delete();
    exp_bytes.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_abort", 32'(done_count), 32'd4);
    check_quiet("quiet_after_abort");

    // Frame E: clean restart from the base address.
    push_frame(); frame_bytes = 0;
    pulse_start(n);
    check_latency();
    wait_done(n, 25, "done_cycle_e");
    @(posedge clk); #1;
    check("done_count_e", 32'(done_count), 32'd5);

    repeat (3) @(negedge clk);
    check("queues_empty", 32'(exp_addr.size() + exp_bytes.size()), 32'd0);
    check("mem_we_never", 32'(we_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
